// File: rtl/prbs31_pkg.sv
// ============================================================================
// prbs31_pkg : shared PRBS31 (x^31 + x^28 + 1) constants, state type, predictor
// Revision   : 1.0
// ============================================================================
`default_nettype none

package prbs31_pkg;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 30;
    localparam int TAP_B    = 27;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic prbs31_next(input logic [PRBS_LEN-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs31_loss_monitor.sv
// ============================================================================
// prbs31_loss_monitor : windowed error counter, flags loss of lock
// Revision            : 1.0
// ============================================================================
`default_nettype none

module prbs31_loss_monitor #(
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_err,
    output logic loss
);

    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int EW    = $clog2(LOSS_THRESH + 1);

    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic [EW-1:0]    win_err_inc;

    always_comb begin
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        loss        = 1'b0;
        win_err_inc = win_err_q + EW'(bit_err);
        if (clear) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (bit_valid) begin
            // Loss is judged on the count including this bit, before any wrap.
            if (bit_err && (win_err_inc == EW'(LOSS_THRESH))) begin
                loss = 1'b1;
            end
            if (win_cnt_q == CNT_W'(WIN_LEN - 1)) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + CNT_W'(1);
                win_err_d = win_err_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prbs31_checker.sv
// ============================================================================
// prbs31_checker : self-synchronising PRBS31 receiver with lock and error count
// Revision       : 1.0
// ============================================================================
`default_nettype none

module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_BITS   = 32,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int FILL_W = $clog2(PRBS_LEN + 1);
    localparam int GOOD_W = $clog2(LOCK_BITS + 1);

    state_t              state_q, state_d;
    logic [PRBS_LEN-1:0] s_q, s_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q, locked_d;

    logic exp_bit;
    logic mon_valid;
    logic mismatch;
    logic loss;

    assign exp_bit   = prbs31_next(s_q);
    assign mon_valid = din_valid && (state_q == LOCKED);
    assign mismatch  = mon_valid && (din != exp_bit);

    prbs31_loss_monitor #(
        .WIN_LEN     (WIN_LEN),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_loss_monitor (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q != LOCKED),
        .bit_valid (mon_valid),
        .bit_err   (mismatch),
        .loss      (loss)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_cnt_d  = fill_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_pulse_d = mismatch;
        err_count_d = err_count_q;

        if (din_valid) begin
            case (state_q)
                SEARCH: begin
                    s_d        = {s_q[PRBS_LEN-2:0], din};
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_q == FILL_W'(PRBS_LEN - 1)) begin
                        state_d    = VERIFY;
                        fill_cnt_d = '0;
                        good_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[PRBS_LEN-2:0], din};
                    // An all-zero register predicts zeros forever; never count that as good.
                    if ((din == exp_bit) && (s_q != '0)) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        if (good_cnt_d == GOOD_W'(LOCK_BITS)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    s_d = {s_q[PRBS_LEN-2:0], exp_bit};
                    if (loss) begin
                        state_d    = SEARCH;
                        fill_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        if (clear_cnt) begin
            err_count_d = '0;
        end else if (mismatch && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            s_q         <= '0;
            fill_cnt_q  <= '0;
            good_cnt_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_cnt_q  <= fill_cnt_d;
            good_cnt_q  <= good_cnt_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs31_checker.sv
// ============================================================================
// tb_prbs31_checker : randomized stimulus against a queue-based stream model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
    wire  [23:0] obs = {locked, err_pulse, err_count, locked4, err_pulse4, err_count4};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prbs31_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs31_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    // Transmit-side generator: b[n] = b[n-31] ^ b[n-28], seeded with 31 ones.
    bit gen_q[$];

    task automatic gen_init();
        gen_q = {};
        repeat (31) gen_q.push_back(1'b1);
    endtask

    task automatic gen_bit(output bit b);
        b = gen_q[0] ^ gen_q[3];
        void'(gen_q.pop_front());
        gen_q.push_back(b);
    endtask

    // Receiver model: last 31 bits kept as a queue (oldest first), an unbounded
    // error tally clamped to each counter width on comparison.
    int m_mode;   // 0 hunting, 1 confirming, 2 tracking
    bit m_rx[$];
    int m_fill, m_good, m_k, m_werr, m_errs;
    bit m_locked, m_pulse;

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_good = 0; m_k = 0; m_werr = 0; m_errs = 0;
        m_locked = 1'b0; m_pulse = 1'b0;
        m_rx = {};
        repeat (31) m_rx.push_back(1'b0);
    endtask

    task automatic model_step(input bit d, input bit v, input bit c);
        bit pred, any1, err;
        err  = 1'b0;
        pred = m_rx[0] ^ m_rx[3];
        any1 = 1'b0;
        foreach (m_rx[i]) if (m_rx[i]) any1 = 1'b1;
        if (v) begin
            case (m_mode)
                0: begin
                    void'(m_rx.pop_front()); m_rx.push_back(d);
                    m_fill++;
                    if (m_fill == 31) begin m_mode = 1; m_good = 0; end
                end
                1: begin
                    if (d == pred && any1) m_good++; else m_good = 0;
                    void'(m_rx.pop_front()); m_rx.push_back(d);
                    if (m_good == 32) begin m_mode = 2; m_k = 0; m_werr = 0; end
                end
                default: begin
                    if (m_k % 64 == 0) m_werr = 0;
                    void'(m_rx.pop_front()); m_rx.push_back(pred);
                    if (d != pred) begin
                        err = 1'b1; m_werr++; m_errs++;
                        if (m_werr == 8) begin m_mode = 0; m_fill = 0; end
                    end
                    m_k++;
                end
            endcase
        end
        if (c) m_errs = 0;
        m_pulse  = err;
        m_locked = (m_mode == 2);
    endtask

    function automatic logic [23:0] expv();
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
        c4  = (m_errs > 15) ? 4'hF : 4'(m_errs);
        return {m_locked, m_pulse, c16, m_locked, m_pulse, c4};
    endfunction

    task automatic cyc(input bit d, input bit v, input bit c);
        din = d; din_valid = v; clear_cnt = c;
        model_step(d, v, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0;
        model_reset();
        gen_init();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_clean(input int n, input string tag);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            cyc(b, 1'b1, 1'b0);
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL %s bit %0d: got %h want %h", tag, i, obs, expv());
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (obs !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs, 24'h0);
        end
        do_reset();
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_clean_lock();
        bit b;
        do_reset();
        for (int n = 1; n <= 10000; n++) begin
            gen_bit(b);
            cyc(b, 1'b1, 1'b0);
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL clean_lock bit %0d: got %h want %h", n, obs, expv());
            end
            if (n == 62 || n == 63) begin
                vectors++;
                if (locked !== (n == 63)) begin
                    miscompares++;
                    $display("FAIL lock_latency bit %0d: got %b want %b", n, locked, (n == 63));
                end
            end
        end
        vectors++;
        if (err_count !== 16'd0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_long: got cnt=%0d locked=%b want cnt=0 locked=1", err_count, locked);
        end
    endtask

    task automatic test_single_error();
        bit b;
        do_reset();
        run_clean(63 + $urandom_range(5, 60), "single_pre");
        gen_bit(b);
        cyc(~b, 1'b1, 1'b0);
        vectors++;
        if (err_pulse !== 1'b1 || obs !== expv()) begin
            miscompares++;
            $display("FAIL single_pulse: got pulse=%b obs=%h want pulse=1 obs=%h", err_pulse, obs, expv());
        end
        gen_bit(b);
        cyc(b, 1'b1, 1'b0);
        vectors++;
        if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL single_after: got pulse=%b cnt=%0d locked=%b want 0/1/1",
                     err_pulse, err_count, locked);
        end
        run_clean(20, "single_post");
    endtask

    task automatic test_loss();
        bit b;
        bit fl[64];
        int nerr, since, nfl;
        do_reset();
        run_clean(63, "loss_pre");
        nfl = 0;
        foreach (fl[i]) fl[i] = 1'b0;
        while (nfl < 8) begin
            int p;
            p = $urandom_range(0, 63);
            if (!fl[p]) begin fl[p] = 1'b1; nfl++; end
        end
        nerr = 0;
        for (int k = 0; k < 64 && nerr < 8; k++) begin
            gen_bit(b);
            if (fl[k]) nerr++;
            cyc(b ^ fl[k], 1'b1, 1'b0);
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL loss_window bit %0d: got %h want %h", k, obs, expv());
            end
        end
        vectors++;
        if (locked !== 1'b0 || err_count !== 16'd8) begin
            miscompares++;
            $display("FAIL loss_drop: got locked=%b cnt=%0d want 0/8", locked, err_count);
        end
        since = 0;
        while (!locked && since < 200) begin
            gen_bit(b);
            cyc(b, 1'b1, 1'b0);
            since++;
        end
        vectors++;
        if (since !== 63 || err_count !== 16'd8) begin
            miscompares++;
            $display("FAIL relock: got %0d bits cnt=%0d want 63 bits cnt=8", since, err_count);
        end

        do_reset();
        run_clean(63, "seven_pre");
        for (int w = 0; w < 5; w++) begin
            foreach (fl[i]) fl[i] = 1'b0;
            nfl = 0;
            while (nfl < 7) begin
                int p;
                p = $urandom_range(0, 63);
                if (!fl[p]) begin fl[p] = 1'b1; nfl++; end
            end
            for (int k = 0; k < 64; k++) begin
                gen_bit(b);
                cyc(b ^ fl[k], 1'b1, 1'b0);
                vectors++;
                if (obs !== expv()) begin
                    miscompares++;
                    $display("FAIL seven_win w%0d bit %0d: got %h want %h", w, k, obs, expv());
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || err_count !== 16'd35) begin
            miscompares++;
            $display("FAIL seven_total: got locked=%b cnt=%0d want 1/35", locked, err_count);
        end
    endtask

    task automatic test_zero_and_gaps();
        bit b, v;
        int nvalid, lock_at;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL zero_stream bit %0d: got %h want %h", i, obs, expv());
            end
        end
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_guard: got locked=%b want 0", locked);
        end

        do_reset();
        nvalid = 0;
        lock_at = -1;
        for (int i = 0; i < 600; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin gen_bit(b); nvalid++; end
            else b = 1'($urandom_range(0, 1));
            cyc(b, v, 1'b0);
            if (locked && lock_at < 0) lock_at = nvalid;
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL gaps cyc %0d: got %h want %h", i, obs, expv());
            end
        end
        vectors++;
        if (lock_at !== 63 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL gaps_lock: got at=%0d cnt=%0d want at=63 cnt=0", lock_at, err_count);
        end
    endtask

    task automatic test_saturation();
        bit b;
        do_reset();
        run_clean(63, "sat_pre");
        for (int e = 0; e < 20; e++) begin
            gen_bit(b);
            cyc(~b, 1'b1, 1'b0);
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL sat_err %0d: got %h want %h", e, obs, expv());
            end
            run_clean(9 + $urandom_range(0, 3), "sat_gap");
        end
        vectors++;
        if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate: got cnt4=%0d cnt=%0d locked=%b want 15/20/1",
                     err_count4, err_count, locked);
        end
        gen_bit(b);
        cyc(~b, 1'b1, 1'b1);
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 16'd0 || err_count4 !== 4'd0) begin
            miscompares++;
            $display("FAIL clear_vs_err: got pulse=%b cnt=%0d cnt4=%0d want 1/0/0",
                     err_pulse, err_count, err_count4);
        end
        run_clean(10, "clear_post");
    endtask

    task automatic test_async_reset();
        bit b;
        do_reset();
        run_clean(70 + $urandom_range(0, 30), "arst_pre");
        gen_bit(b);
        cyc(~b, 1'b1, 1'b0);
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL arst_pre_err: got %h want %h", obs, expv());
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: got locked=%b pulse=%b cnt=%0d want 0/0/0",
                     locked, err_pulse, err_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen_init();
        run_clean(70, "arst_post");
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss();
        test_zero_and_gaps();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
